// File: rtl/elastic_pipe_reg.sv
// Purpose : elastic valid/ready register pipeline of DEPTH stages, optional skid entry in front of stage 0.
// Latency : DEPTH cycles from accept to out_valid with an empty, unstalled pipe (skid entry empty).
// Backpr. : stalled stages hold; in_ready follows out_ready when full, or is registered when the skid is built.
//
// Build option: define ELASTIC_PIPE_SKID_EN to add the one-entry skid buffer. With it, in_ready is
// driven only by the skid valid flag and flush, so there is no combinational out_ready->in_ready path.
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   flush                 synchronous clear of every stage (and the skid entry), input discarded
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and head-stage payload
//   occupancy             number of valid entries held, skid entry included
module elastic_pipe_reg #(
    parameter int BW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BW-1:0]              in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BW-1:0]              out_data,
    output logic [$clog2(DEPTH+2)-1:0] occupancy
);

    localparam int OW = $clog2(DEPTH+2);

    logic [DEPTH-1:0] stg_vld;
    logic [BW-1:0]    stg_dat [DEPTH];
    logic [DEPTH-1:0] stg_load;

    // What each stage would load: its upstream neighbour, or the stage-0 source.
    logic [DEPTH-1:0] prev_vld;
    logic [BW-1:0]    prev_dat [DEPTH];

    logic             src_vld;
    logic [BW-1:0]    src_dat;
    logic             skid_vld;

    // A stage can load when some stage at or downstream of it is empty, or the head pops:
    // in either case every valid entry from that hole forward shifts by one.
    always_comb begin
        logic full_from;
        full_from = 1'b1;
        stg_load  = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            full_from   = full_from & stg_vld[i];
            stg_load[i] = out_ready | ~full_from;
        end
    end

`ifdef ELASTIC_PIPE_SKID_EN
    logic [BW-1:0] skid_dat;
    logic          in_acc;

    assign in_ready = ~skid_vld & ~flush;
    assign in_acc   = in_valid & in_ready;
    // A parked word always drains before anything newer; in_ready is low while it is parked.
    assign src_vld  = skid_vld | in_acc;
    assign src_dat  = skid_vld ? skid_dat : in_data;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (flush) begin
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (skid_vld && stg_load[0]) begin
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (in_acc && !stg_load[0]) begin
            skid_vld <= 1'b1;
            skid_dat <= in_data;
        end
    end
`else
    assign skid_vld = 1'b0;
    assign in_ready = stg_load[0] & ~flush;
    assign src_vld  = in_valid & in_ready;
    assign src_dat  = in_data;
`endif

    always_comb begin
        prev_vld[0] = src_vld;
        prev_dat[0] = src_vld ? src_dat : '0;
        for (int i = 1; i < DEPTH; i++) begin
            prev_vld[i] = stg_vld[i-1];
            prev_dat[i] = stg_dat[i-1];
        end
    end

    // Invalid stages always hold zero data, so copying a neighbour's data unconditionally
    // keeps the "data is 0 when not valid" property as entries shift.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stg_vld <= '0;
            for (int i = 0; i < DEPTH; i++) stg_dat[i] <= '0;
        end else if (flush) begin
            stg_vld <= '0;
            for (int i = 0; i < DEPTH; i++) stg_dat[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (stg_load[i]) begin
                    stg_vld[i] <= prev_vld[i];
                    stg_dat[i] <= prev_dat[i];
                end
            end
        end
    end

    always_comb begin
        occupancy = OW'(skid_vld);
        for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OW'(stg_vld[i]);
    end

    assign out_valid = stg_vld[DEPTH-1];
    assign out_data  = stg_dat[DEPTH-1];

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Purpose : directed checks on a DEPTH=2 pipe, then a random scoreboard run on DEPTH 1, 3 and 8.
// Latency : outputs sampled 1-2 time units after the falling edge, inputs driven on the falling edge.
// Backpr. : random out_ready stalls on the scoreboard instances.
module tb_elastic_pipe_reg;

`ifdef ELASTIC_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    elastic_pipe_reg #(.BW(32), .DEPTH(2)) u_dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    // Random scoreboard instances.
    localparam int NR = 3;
    logic        r_iv [NR];
    logic        r_or [NR];
    logic        r_ir [NR];
    logic        r_ov [NR];
    logic [31:0] r_id [NR];
    logic [31:0] r_od [NR];
    logic [3:0]  r_occ[NR];
    logic        r_flush = 1'b0;

    for (genvar g = 0; g < NR; g++) begin : g_rnd
        localparam int D = (g == 0) ? 1 : (g == 1) ? 3 : 8;
        logic [$clog2(D+2)-1:0] occ;
        logic                   ir, ov;
        logic [31:0]            od;
        elastic_pipe_reg #(.BW(32), .DEPTH(D)) u_rnd (
            .clk       (clk),
            .n_rst     (n_rst),
            .flush     (r_flush),
            .in_valid  (r_iv[g]),
            .in_ready  (ir),
            .in_data   (r_id[g]),
            .out_valid (ov),
            .out_ready (r_or[g]),
            .out_data  (od),
            .occupancy (occ)
        );
        assign r_ir[g]  = ir;
        assign r_ov[g]  = ov;
        assign r_od[g]  = od;
        assign r_occ[g] = 4'(occ);
    end

    int acc_cnt [NR];
    int pop_cnt [NR];
    logic acc_f [NR];
    logic pop_f [NR];

    initial begin
        n_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        for (int g = 0; g < NR; g++) begin
            r_iv[g] = 1'b0; r_or[g] = 1'b0; r_id[g] = '0; acc_cnt[g] = 0; pop_cnt[g] = 0;
        end

        // Reset state
        #3;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data",  out_data,       32'd0);
        check_val("rst_occ",       32'(occupancy), 32'd0);
        @(negedge clk); n_rst = 1'b1;
        #1 check_val("rst_in_ready", 32'(in_ready), 32'd1);

        // Two back-to-back words, DEPTH cycles latency each, order kept
        in_valid = 1'b1; in_data = 32'hA5A5_0001;
        @(negedge clk); in_data = 32'hA5A5_0002;
        #1 check_val("lat_not_early", 32'(out_valid), 32'd0);
        @(negedge clk); in_valid = 1'b0;
        #1 check_val("w1_valid", 32'(out_valid), 32'd1);
        check_val("w1_data", out_data, 32'hA5A5_0001);
        check_val("w1_occ",  32'(occupancy), 32'd2);
        @(negedge clk);
        #1 check_val("w2_data", out_data, 32'hA5A5_0002);
        check_val("w2_occ",  32'(occupancy), 32'd1);
        @(negedge clk);
        #1 check_val("drain_valid", 32'(out_valid), 32'd0);
        check_val("drain_data",  out_data, 32'd0);
        check_val("drain_occ",   32'(occupancy), 32'd0);

        // Stalled output, three pushes
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5_0001;
        @(negedge clk); in_data = 32'hA5A5_0002;
        @(negedge clk); in_data = 32'hA5A5_0003;
        #1 check_val("stall_third_rdy", 32'(in_ready), SKID ? 32'd1 : 32'd0);
        @(negedge clk); in_valid = 1'b0;
        #1 check_val("stall_occ",  32'(occupancy), SKID ? 32'd3 : 32'd2);
        check_val("stall_data", out_data, 32'hA5A5_0001);
        check_val("stall_rdy",  32'(in_ready), 32'd0);

        // Full pipe, simultaneous push and pop
        in_valid = 1'b1; in_data = 32'hA5A5_0004; out_ready = 1'b1;
        #1 check_val("full_pp_rdy", 32'(in_ready), SKID ? 32'd0 : 32'd1);
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
        #1 check_val("full_pp_occ",  32'(occupancy), 32'd2);
        check_val("full_pp_data", out_data, 32'hA5A5_0002);

        // Flush with a concurrent input word
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_0005;
        #1 check_val("flush_rdy", 32'(in_ready), 32'd0);
        @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1 check_val("flush_valid", 32'(out_valid), 32'd0);
        check_val("flush_data",  out_data, 32'd0);
        check_val("flush_occ",   32'(occupancy), 32'd0);
        check_val("flush_rdy_after", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1 check_val("flush_no_ghost", 32'(out_valid), 32'd0);

        // Asynchronous reset with two words held
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5_0006;
        @(negedge clk); in_data = 32'hA5A5_0007;
        @(negedge clk); in_valid = 1'b0;
        #1 check_val("pre_rst_occ", 32'(occupancy), 32'd2);
        #2 n_rst = 1'b0;
        #1 check_val("arst_valid", 32'(out_valid), 32'd0);
        check_val("arst_data",  out_data, 32'd0);
        check_val("arst_occ",   32'(occupancy), 32'd0);
        @(negedge clk); #1 n_rst = 1'b1;
        #1 check_val("arst_rdy", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        #1 check_val("arst_no_partial", 32'(out_valid), 32'd0);

        // Random traffic, in-order lossless delivery and occupancy against the counters
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            for (int g = 0; g < NR; g++) begin
                r_iv[g] = 1'($urandom_range(0, 1));
                r_or[g] = 1'($urandom_range(0, 1));
                r_id[g] = 32'(acc_cnt[g]);
            end
            #2;
            for (int g = 0; g < NR; g++) begin
                check_val("rnd_occ", 32'(r_occ[g]), 32'(acc_cnt[g] - pop_cnt[g]));
                acc_f[g] = r_iv[g] & r_ir[g];
                pop_f[g] = r_ov[g] & r_or[g];
                if (r_ov[g]) check_val("rnd_order", r_od[g], 32'(pop_cnt[g]));
                else         check_val("rnd_idle_data", r_od[g], 32'd0);
            end
            @(posedge clk);
            for (int g = 0; g < NR; g++) begin
                if (acc_f[g]) acc_cnt[g]++;
                if (pop_f[g]) pop_cnt[g]++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elastic_pipe_reg.md
ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 The block SHALL have parameter BW, default 32: payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2: number of register stages, legal range 1..8.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port flush  input  1  synchronous clear of all stages (bubble injection).
REQ-006 The block SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 The block SHALL have port in_ready  output  1  block accepts payload this cycle.
REQ-008 The block SHALL have port in_data  input  BW  upstream payload.
REQ-009 The block SHALL have port out_valid  output  1  head stage holds valid payload.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts payload (low = stall).
REQ-011 The block SHALL have port out_data  output  BW  head stage payload.
REQ-012 The block SHALL have port occupancy  output  $clog2(DEPTH+2)  count of valid entries held, skid entry included.

Function
REQ-013 Each stage SHALL hold one valid bit and one BW-bit data word; stage 0 is the input, stage DEPTH-1 is the head.
REQ-014 Transfer SHALL occur on input when in_valid && in_ready, on output when out_valid && out_ready.
REQ-015 Stage i SHALL load from stage i-1 (stage 0 from input) when it is empty or its contents advance in the same cycle.
REQ-016 A stage that empties without reloading SHALL have its data cleared to 0, so out_data is 0 whenever out_valid is 0.
REQ-017 A stalled stage (downstream full, not advancing) SHALL hold valid and data unchanged.
REQ-018 With an empty, unstalled pipe, a word accepted at edge N SHALL appear on out_valid/out_data after edge N+DEPTH-1 (DEPTH cycles of latency including the accept edge).
REQ-019 Full throughput SHALL be sustained: one accept and one output per cycle when in_valid and out_ready are held high.
REQ-020 When all stages are valid, in_ready SHALL equal out_ready (without skid), so a simultaneous push and pop on a full pipe is accepted.
REQ-021 Payload order SHALL be preserved; no word SHALL be dropped or duplicated except by flush.
REQ-022 flush SHALL take priority over all transfers: on the edge it is sampled high, every valid bit and data word SHALL clear to 0 and any concurrent input word SHALL be discarded.
REQ-023 in_ready SHALL be 0 while flush is high.
REQ-024 occupancy SHALL equal the number of valid entries after each edge: +1 on accept only, -1 on output only, unchanged on both, 0 after flush.

Reset
REQ-025 While n_rst is low, all valid bits, data words and the skid entry SHALL be 0 asynchronously; out_valid = 0, out_data = 0, occupancy = 0.
REQ-026 in_ready SHALL be 1 in the first cycle after n_rst deasserts when flush is low.
REQ-027 Reset asserted mid-transfer SHALL discard all contents; no partial word SHALL emerge after release.

Configuration
REQ-028 Macro ELASTIC_PIPE_SKID_EN SHALL, when defined, add a one-entry skid buffer before stage 0 and drive in_ready directly from a register (in_ready = !skid_valid && !flush), breaking the combinational out_ready->in_ready path.
REQ-029 With ELASTIC_PIPE_SKID_EN, a word accepted while stage 0 cannot load SHALL be held in the skid entry and drained into stage 0 before any newer word; latency is unchanged when the skid entry is empty; occupancy maximum is DEPTH+1; flush clears the skid entry.
REQ-030 Without ELASTIC_PIPE_SKID_EN, no skid storage SHALL exist, in_ready is combinational per REQ-015/REQ-020, and occupancy maximum is DEPTH.

Verification
REQ-031 DEPTH=2, out_ready=1, push 0xA5A5_0001 then 0xA5A5_0002 on consecutive cycles -> out_valid asserted 2 cycles after each accept, same order, occupancy never exceeds 2.
REQ-032 DEPTH=2, out_ready=0, push 3 words -> first 2 accepted, in_ready=0 on third (no skid) / third held in skid with occupancy=3 (skid), out_data stays 0x...0001.
REQ-033 Full pipe, in_valid=1 and out_ready=1 together -> one pop and one push same edge, occupancy unchanged at 2.
REQ-034 Full pipe, assert flush for one cycle with in_valid=1 -> next cycle out_valid=0, out_data=0, occupancy=0, flushed input word never appears.
REQ-035 n_rst pulsed low asynchronously between edges with 2 valid words -> outputs 0 immediately, in_ready=1 first cycle after release.
REQ-036 Random in_valid/out_ready at 50% for 10000 cycles, DEPTH in {1,3,8}, both macro settings -> scoreboard shows in-order, lossless delivery and occupancy matching the model.
